// File: rtl/data_read_capture.sv
// data_read_capture: arm/pre-trigger/trigger/post-trigger capture into a circular LVDS sample buffer
module data_read_capture #(
  parameter int BUFFER_SIZE = 8192,
  parameter int ADDR_W      = 14
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic [3:0]        din,
  input  logic              din_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_in,
  input  logic [ADDR_W-1:0] pretrig_len,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);
  localparam logic [ADDR_W-1:0] MASK  = ADDR_W'(BUFFER_SIZE - 1);
  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W + 1)'(BUFFER_SIZE);
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr, pre_lat, len_clamp;
  logic [ADDR_W:0]   cnt, cnt_inc;
  logic              trig_q, edge_hit, start, write;
  assign len_clamp = pretrig_len > MASK ? MASK : pretrig_len;
  assign start     = arm && !abort && (state == IDLE || state == DONE);
  assign write     = din_valid && !abort && (state == PRE || state == WAIT || state == POST);
  assign edge_hit  = trig_in && !trig_q && !abort && state == WAIT;
  // the trigger cycle restarts the count, so its own sample is post-trigger sample one
  assign cnt_inc   = (edge_hit ? '0 : cnt) + (ADDR_W + 1)'(din_valid);
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (start) state_nx = len_clamp == '0 ? WAIT : PRE;
    else if (state == PRE && cnt_inc == {1'b0, pre_lat}) state_nx = WAIT;
    else if ((state == POST || edge_hit) && cnt_inc == DEPTH - {1'b0, pre_lat}) state_nx = DONE;
    else if (edge_hit) state_nx = POST;
  end
  always_ff @(posedge wr_clk or negedge wr_rst_n)
    if (!wr_rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      trig_q     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      ptr        <= '0;
      pre_lat    <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      trig_q <= trig_in;
      wr_en  <= write;
      busy   <= state_nx inside {PRE, WAIT, POST};
      done   <= state_nx == DONE;
      cnt    <= start ? '0 : (state == PRE || state == POST || edge_hit) ? cnt_inc : cnt;
      if (start) begin
        pre_lat <= len_clamp;
        ptr     <= '0;
      end else if (write) ptr <= (ptr + 1'b1) & MASK;
      if (write) begin
        wr_addr <= ptr;
        wr_data <= din;
      end
      if (edge_hit) begin
        trig_addr  <= ptr;
        start_addr <= (ptr - pre_lat) & MASK;
      end
    end
  end
endmodule

// File: tb/tb_data_read_capture.sv
// tb_data_read_capture: scoreboard bench for data_read_capture with a 16-deep buffer
module tb_data_read_capture;
  localparam int BS = 16;
  localparam int AW = 5;
  logic          wr_clk = 1'b0, wr_rst_n = 1'b0;
  logic [3:0]    din = '0;
  logic          din_valid = 1'b0, arm = 1'b0, abort = 1'b0, trig_in = 1'b0;
  logic [AW-1:0] pretrig_len = '0;
  logic [AW-1:0] wr_addr, trig_addr, start_addr;
  logic [3:0]    wr_data;
  logic          wr_en, busy, done;
  logic [AW+3:0] exp_q[$];
  logic [AW+3:0] exp_w;
  int            exp_addr, wr_cnt, errors = 0, checks = 0;

  data_read_capture #(.BUFFER_SIZE(BS), .ADDR_W(AW)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .din(din), .din_valid(din_valid),
    .arm(arm), .abort(abort), .trig_in(trig_in), .pretrig_len(pretrig_len),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done),
    .trig_addr(trig_addr), .start_addr(start_addr)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge wr_clk)
    if (wr_rst_n && wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("unexpected_write", {wr_addr, wr_data}, '1);
      else begin
        exp_w = exp_q.pop_front();
        check("write", {wr_addr, wr_data}, exp_w);
      end
    end

  task automatic step(input logic v, input logic [3:0] d, input logic t, input bit push);
    din_valid = v;
    din       = d;
    trig_in   = t;
    if (push && v) begin
      exp_q.push_back({AW'(exp_addr), d});
      exp_addr = (exp_addr + 1) % BS;
    end
    @(posedge wr_clk); #1;
  endtask

  task automatic do_arm(input logic [AW-1:0] len, input logic t, input logic ab);
    pretrig_len = len;
    arm         = 1'b1;
    abort       = ab;
    din_valid   = 1'b0;
    trig_in     = t;
    if (!ab) begin
      exp_addr = 0;
      wr_cnt   = 0;
    end
    @(posedge wr_clk); #1;
    arm         = 1'b0;
    abort       = 1'b0;
    pretrig_len = $urandom_range(0, 31);
  endtask

  task automatic settle(input string tag, input int pulses);
    for (int i = 0; i < 4; i++) step(1'b1, 4'hf, trig_in, 1'b0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_pulses"}, wr_cnt, pulses);
  endtask

  initial begin
    repeat (2) @(posedge wr_clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addrs", {wr_addr, trig_addr, start_addr}, 0);
    wr_rst_n = 1'b1;
    @(posedge wr_clk); #1;

    // basic: pre 4, trigger on the 11th sample
    do_arm(5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      step(1'b1, 4'(i), i >= 10, 1'b1);
      if (i == 5) check("a_busy", busy, 1);
    end
    settle("a", 22);
    check("a_done", done, 1);
    check("a_busy_done", busy, 0);
    check("a_trig_addr", trig_addr, 10);
    check("a_start_addr", start_addr, 6);

    // pre 0, trigger already high at arm; arm from DONE restarts at addr 0
    do_arm(5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3), 1'b1, 1'b1);
    check("b_no_trig", trig_addr, 10);
    check("b_busy", busy, 1);
    step(1'b1, 4'h9, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i * 3), 1'b1, 1'b1);
    settle("b", 22);
    check("b_done", done, 1);
    check("b_trig_addr", trig_addr, 6);
    check("b_start_addr", start_addr, 6);

    // edges during PRE are ignored
    do_arm(5'd8, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b1, 4'(i ^ 5), i == 3 || i == 6 || i >= 10, 1'b1);
    settle("c", 18);
    check("c_done", done, 1);
    check("c_trig_addr", trig_addr, 10);
    check("c_start_addr", start_addr, 2);

    // valid every third cycle
    do_arm(5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      step(1'b1, 4'(15 - i), i >= 10, 1'b1);
      step(1'b0, 4'h0, i >= 10, 1'b0);
      step(1'b0, 4'h0, i >= 10, 1'b0);
    end
    settle("d", 22);
    check("d_done", done, 1);
    check("d_trig_addr", trig_addr, 10);
    check("d_start_addr", start_addr, 6);

    // abort mid-POST, then arm+abort together
    do_arm(5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 4'(i), i >= 10, 1'b1);
    abort = 1'b1;
    step(1'b1, 4'h7, 1'b1, 1'b0);
    abort = 1'b0;
    settle("e", 12);
    check("e_busy", busy, 0);
    check("e_done", done, 0);
    check("e_trig_held", {trig_addr, start_addr}, {5'd10, 5'd6});
    do_arm(5'd2, 1'b0, 1'b1);
    settle("e2", 12);
    check("e2_busy", busy, 0);

    // length clamped to BS-1, trigger ends capture immediately
    do_arm(5'd20, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i + 1), i >= 15, 1'b1);
    settle("f", 16);
    check("f_done", done, 1);
    check("f_trig_addr", trig_addr, 15);
    check("f_start_addr", start_addr, 0);

    // asynchronous reset during POST
    do_arm(5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 4'(i), i >= 10, 1'b1);
    step(1'b1, 4'h3, 1'b1, 1'b0);
    check("g_inflight", wr_en, 1);
    #1 wr_rst_n = 1'b0;
    #1;
    check("g_rst_wr_en", wr_en, 0);
    check("g_rst_busy", busy, 0);
    check("g_rst_addrs", {wr_addr, trig_addr, start_addr}, 0);
    @(posedge wr_clk); #1;
    wr_rst_n = 1'b1;
    settle("g", 11);
    check("g_idle_busy", busy, 0);
    check("g_idle_done", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_read_capture.md
# data_read_capture

Capture controller directly upstream of the LVDS data buffer. It takes the sampled 4-bit LVDS stream and produces the buffer's write port (`wr_addr`, `wr_data`, `wr_en`). It implements an arm / pre-trigger / trigger / post-trigger acquisition that fills the buffer exactly once per arm. It reports the trigger and oldest-sample addresses so the read side can unroll the circular capture.

## Interface

- `BUFFER_SIZE`, 8192: buffer depth in samples; must be a power of two, ≤ 2^ADDR_W.
- `ADDR_W`, 14: width of all address and length buses.

- `wr_clk`  in  1  capture clock; the same clock as the buffer write port.
- `wr_rst_n`  in  1  reset; asynchronous, active-low.
- `din`  in  4  sampled LVDS data, one bit per lane.
- `din_valid`  in  1  `din` holds a new sample this cycle.
- `arm`  in  1  one-cycle pulse that starts an acquisition.
- `abort`  in  1  level; returns the block to IDLE.
- `trig_in`  in  1  trigger level, already synchronous to `wr_clk`; rising-edge sensitive.
- `pretrig_len`  in  ADDR_W  number of samples to keep before the trigger; latched on `arm`.
- `wr_addr`  out  ADDR_W  buffer write address.
- `wr_data`  out  4  buffer write data.
- `wr_en`  out  1  buffer write strobe.
- `busy`  out  1  high in PRE, WAIT and POST.
- `done`  out  1  high in DONE.
- `trig_addr`  out  ADDR_W  address of the first post-trigger sample.
- `start_addr`  out  ADDR_W  address of the oldest valid sample, (`trig_addr` − latched `pretrig_len`) mod BUFFER_SIZE.

## Operation

- **States:** IDLE, PRE, WAIT, POST, DONE.
- **Reset:** state IDLE. All outputs, the write pointer, the counters, the latched length and the trigger-history register are 0.
- **Length latch:** on `arm`, store `pretrig_len`, clamped to BUFFER_SIZE−1, as `pre_lat`.
- **IDLE or DONE + `arm`:**
  - clear the write pointer and sample counter to 0;
  - go to PRE, or directly to WAIT if `pre_lat` = 0.
- **`arm` in PRE, WAIT or POST:** ignored.
- **Sample writes:** every `din_valid` cycle in PRE, WAIT or POST writes `din` at the write pointer.
  - The pointer then increments modulo BUFFER_SIZE; upper address bits stay 0.
  - No other event writes.
- **PRE:** counts valid samples. When the count reaches `pre_lat` (including the sample this cycle), go to WAIT. Trigger edges in PRE are ignored.
- **WAIT:** keeps writing circularly.
- **Trigger edge:** `trig_in & ~trig_q`, where `trig_q` is `trig_in` registered every cycle in all states.
  - A trigger already high at `arm` does not fire until it falls and rises again.
- **Edge in WAIT at cycle n:**
  - `trig_addr` ← current pointer value;
  - `start_addr` ← (pointer − `pre_lat`) mod BUFFER_SIZE;
  - post counter ← 0; go to POST.
  - If `din_valid` is high in cycle n, that sample is the first post-trigger sample and is written at `trig_addr`.
- **POST:** counts valid samples, including any sample from cycle n. When the count reaches BUFFER_SIZE − `pre_lat`, go to DONE. The last write lands at `start_addr` − 1.
- **DONE:** no writes. `trig_addr`/`start_addr` are held until the next `arm`.
- **`abort` high:** go to IDLE from any state, with no write in that cycle. `abort` beats `arm` in the same cycle. `trig_addr`/`start_addr` keep their last values.
- **`pretrig_len` changes after `arm`:** no effect until the next `arm`.

## Timing

- `wr_en`, `wr_addr` and `wr_data` are registered: a sample at cycle k with `din_valid` appears on the write port at cycle k+1, with `wr_en` high for exactly one cycle.
- State transitions take effect on the clock edge after the qualifying event.
- `busy`/`done` are registered, decoded from the state.
- `trig_addr`/`start_addr` update one cycle after the edge.
- Throughput: one sample per cycle when `din_valid` is held high; gaps in `din_valid` stall all counters.
- Reset asserted mid-acquisition clears everything immediately, including any `wr_en` in flight; it is not deferred to the clock.

## Test plan

- **Reset values:** assert `wr_rst_n`=0 mid-POST → all outputs 0 asynchronously, state IDLE; after release `arm` is needed to restart.
- **Basic acquisition** (BUFFER_SIZE=16, `pretrig_len`=4, `din_valid` constant, data = incrementing nibble):
  - stimulus: `arm`, then trigger rise on the 11th sample cycle;
  - response: pre/wait writes to addr 0..9; `trig_addr`=10, `start_addr`=6; 12 post writes to addr 10..15, 0..5; then `done`=1 and exactly 22 `wr_en` pulses in total.
- **`pretrig_len`=0 with `trig_in` high at `arm`:**
  - response: straight to WAIT and no trigger while `trig_in` stays high;
  - stimulus: fall then rise of `trig_in` → `trig_addr`=`start_addr`, 16 post writes.
- **Trigger edges during PRE** (`pretrig_len`=8, rising edges after samples 3 and 6): ignored; the first edge after 8 samples sets `trig_addr`.
- **`din_valid` gaps:**
  - stimulus: valid every third cycle;
  - response: `wr_en` only one cycle after each valid, addresses contiguous, counts identical to the continuous case.
- **Abort and rearm:**
  - `abort` mid-POST → IDLE, no further writes, `busy`=0;
  - `arm`+`abort` in the same cycle → stays IDLE;
  - `arm` in DONE → new acquisition from addr 0 with a fresh `pretrig_len`.
